mem_responder: RTL and testbench

Memory-side responder for the multicycle accumulator CPU's data/instruction memory port. It accepts single-word read and write requests issued by the control FSM (`MemRead`/`MemWrite` with the IorD-selected address) and serves them from an internal word array. Each access has a configurable number of wait states and returns a one-cycle `Ready` pulse. It flags illegal or out-of-range requests instead of performing them.

---
 rtl/mem_responder.sv | 134 +++++++++++++
 tb/tb_mem_responder.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_responder.sv
// mem_responder: single-port word memory behind the multicycle CPU's
// MemRead/MemWrite handshake. Each request is latched, delayed by WAIT wait
// states, performed once, and acknowledged with a one-cycle Ready pulse.
// Illegal or out-of-range requests complete with Err instead of touching
// the array.
module mem_responder #(
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned ADDR_W     = 16,
  parameter int unsigned DEPTH_LOG2 = 10,
  parameter int unsigned WAIT       = 1
) (
  input  logic              CLK,
  input  logic              Reset,
  input  logic              MemRead,
  input  logic              MemWrite,
  input  logic [ADDR_W-1:0] Addr,
  input  logic [DATA_W-1:0] WrData,
  output logic [DATA_W-1:0] RdData,
  output logic              Ready,
  output logic              Err,
  output logic              Busy
);

  localparam int unsigned DEPTH    = 1 << DEPTH_LOG2;
  localparam logic [3:0]  WAIT_CNT = 4'(WAIT);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_WAITS  = 3'd1;
  localparam logic [2:0] S_ACCESS = 3'd2;
  localparam logic [2:0] S_RESP   = 3'd3;
  localparam logic [2:0] S_HOLD   = 3'd4;

  logic [2:0]            state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic [DEPTH_LOG2-1:0] addr_q, addr_d;
  logic [DATA_W-1:0]     wdata_q, wdata_d;
  logic                  is_wr_q, is_wr_d;
  logic                  err_q, err_d;
  logic [DATA_W-1:0]     rdata_q, rdata_d;

  logic [DATA_W-1:0]     mem_q [DEPTH];
  logic                  mem_we;
  logic                  req;
  logic                  addr_oor;

  assign req      = MemRead | MemWrite;
  assign addr_oor = (Addr >> DEPTH_LOG2) != '0;

  // Next-state, request latching and access decode
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    is_wr_d = is_wr_q;
    err_d   = err_q;
    rdata_d = rdata_q;
    mem_we  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req) begin
          addr_d  = Addr[DEPTH_LOG2-1:0];
          wdata_d = WrData;
          is_wr_d = MemWrite;
          err_d   = (MemRead & MemWrite) | addr_oor;
          cnt_d   = WAIT_CNT;
          state_d = (WAIT_CNT == 4'd0) ? S_ACCESS : S_WAITS;
        end
      end
      S_WAITS: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) begin
          state_d = S_ACCESS;
        end
      end
      S_ACCESS: begin
        state_d = S_RESP;
        if (err_q) begin
          rdata_d = '0;
        end else if (is_wr_q) begin
          mem_we = 1'b1;
        end else begin
          rdata_d = mem_q[addr_q];
        end
      end
      S_RESP: begin
        state_d = req ? S_HOLD : S_IDLE;
      end
      S_HOLD: begin
        if (!req) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Control and response registers with asynchronous active-low reset
  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      is_wr_q <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      is_wr_q <= is_wr_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
    end
  end

  // Word array: not reset; mem_we is gated by state_q, so a reset before the
  // ACCESS exit edge cancels the pending write
  always_ff @(posedge CLK) begin
    if (mem_we) begin
      mem_q[addr_q] <= wdata_q;
    end
  end

  assign RdData = rdata_q;
  assign Ready  = (state_q == S_RESP);
  assign Err    = (state_q == S_RESP) & err_q;
  assign Busy   = (state_q != S_IDLE);

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: three instances (WAIT = 0, 1, 3) share one
// request stream. Directed vector table, hand-written corner sequences
// (held request, reset mid-write, input changes while waiting) and a
// randomized phase checked against a per-instance memory model.
module tb_mem_responder;

  localparam int NDUT = 3;
  localparam int WL [NDUT] = '{0, 1, 3};

  logic        CLK = 1'b0;
  logic        Reset;
  logic        MemRead;
  logic        MemWrite;
  logic [15:0] Addr;
  logic [15:0] WrData;

  logic [15:0] rdd [NDUT];
  logic        rdy [NDUT];
  logic        er  [NDUT];
  logic        bsy [NDUT];

  always #5 CLK = ~CLK;

  mem_responder #(.DATA_W(16), .ADDR_W(16), .DEPTH_LOG2(10), .WAIT(0)) u_w0 (
    .CLK(CLK), .Reset(Reset), .MemRead(MemRead), .MemWrite(MemWrite),
    .Addr(Addr), .WrData(WrData),
    .RdData(rdd[0]), .Ready(rdy[0]), .Err(er[0]), .Busy(bsy[0])
  );

  mem_responder #(.DATA_W(16), .ADDR_W(16), .DEPTH_LOG2(10), .WAIT(1)) u_w1 (
    .CLK(CLK), .Reset(Reset), .MemRead(MemRead), .MemWrite(MemWrite),
    .Addr(Addr), .WrData(WrData),
    .RdData(rdd[1]), .Ready(rdy[1]), .Err(er[1]), .Busy(bsy[1])
  );

  mem_responder #(.DATA_W(16), .ADDR_W(16), .DEPTH_LOG2(10), .WAIT(3)) u_w3 (
    .CLK(CLK), .Reset(Reset), .MemRead(MemRead), .MemWrite(MemWrite),
    .Addr(Addr), .WrData(WrData),
    .RdData(rdd[2]), .Ready(rdy[2]), .Err(er[2]), .Busy(bsy[2])
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: one word array and last-response register per instance
  logic [15:0] mem_m  [NDUT][1024];
  logic [15:0] lastrd [NDUT];

  // Per-transaction observations
  int          r_cnt    [NDUT];
  int          r_at     [NDUT];
  logic        r_err    [NDUT];
  logic [15:0] r_dat    [NDUT];
  logic        r_b1     [NDUT];
  logic        r_bh     [NDUT];
  logic        r_bend   [NDUT];
  int          r_orphan [NDUT];

  typedef struct {
    logic        rd;
    logic        wr;
    logic [15:0] a;
    logic [15:0] d;
    logic        exp_err;
    logic [15:0] exp_rd;
  } vec_t;

  vec_t tbl [14];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  function automatic void model_apply(input logic rd, input logic wr,
                                      input logic [15:0] a, input logic [15:0] d);
    logic bad;
    bad = (rd && wr) || (a >= 16'd1024);
    for (int i = 0; i < NDUT; i++) begin
      if (bad)     lastrd[i] = 16'h0000;
      else if (wr) mem_m[i][a[9:0]] = d;
      else         lastrd[i] = mem_m[i][a[9:0]];
    end
  endfunction

  task automatic sample(input int k, input int hold);
    for (int i = 0; i < NDUT; i++) begin
      if (rdy[i]) begin
        r_cnt[i]++;
        if (r_cnt[i] == 1) begin
          r_at[i]  = k;
          r_err[i] = er[i];
          r_dat[i] = rdd[i];
        end
      end
      if (er[i] && !rdy[i]) r_orphan[i]++;
      if (k == 1)        r_b1[i]   = bsy[i];
      if (k == hold)     r_bh[i]   = bsy[i];
      if (k == hold + 1) r_bend[i] = bsy[i];
    end
  endtask

  // Request is seen high on exactly `hold` rising edges, then dropped.
  task automatic run_txn(input logic rd, input logic wr, input logic [15:0] a,
                         input logic [15:0] d, input int hold, input bit scr);
    @(negedge CLK);
    MemRead  = rd;
    MemWrite = wr;
    Addr     = a;
    WrData   = d;
    for (int i = 0; i < NDUT; i++) begin
      r_cnt[i] = 0; r_at[i] = -1; r_err[i] = 1'b0; r_dat[i] = 16'h0;
      r_b1[i] = 1'b0; r_bh[i] = 1'b0; r_bend[i] = 1'b1; r_orphan[i] = 0;
    end
    for (int k = 1; k <= hold + 2; k++) begin
      @(negedge CLK);
      sample(k, hold);
      if (k == 1 && scr) begin
        Addr   = Addr ^ 16'h0003;
        WrData = ~WrData;
      end
      if (k == hold) begin
        MemRead  = 1'b0;
        MemWrite = 1'b0;
      end
    end
  endtask

  task automatic check_txn(input string nm, input logic ee,
                           input logic [15:0] e0, input logic [15:0] e1, input logic [15:0] e2);
    logic [15:0] ed [NDUT];
    ed[0] = e0; ed[1] = e1; ed[2] = e2;
    for (int i = 0; i < NDUT; i++) begin
      chk($sformatf("%s w%0d ready_count", nm, WL[i]), r_cnt[i], 1);
      chk($sformatf("%s w%0d ready_cycle", nm, WL[i]), r_at[i], WL[i] + 2);
      chk($sformatf("%s w%0d err", nm, WL[i]), {31'b0, r_err[i]}, {31'b0, ee});
      chk($sformatf("%s w%0d rddata", nm, WL[i]), {16'b0, r_dat[i]}, {16'b0, ed[i]});
      chk($sformatf("%s w%0d busy_first", nm, WL[i]), {31'b0, r_b1[i]}, 1);
      chk($sformatf("%s w%0d busy_held", nm, WL[i]), {31'b0, r_bh[i]}, 1);
      chk($sformatf("%s w%0d busy_after", nm, WL[i]), {31'b0, r_bend[i]}, 0);
      chk($sformatf("%s w%0d err_wo_ready", nm, WL[i]), r_orphan[i], 0);
    end
  endtask

  task automatic model_txn(input string nm, input logic rd, input logic wr,
                           input logic [15:0] a, input logic [15:0] d,
                           input int hold, input bit scr);
    logic ee;
    ee = (rd && wr) || (a >= 16'd1024);
    run_txn(rd, wr, a, d, hold, scr);
    model_apply(rd, wr, a, d);
    check_txn(nm, ee, lastrd[0], lastrd[1], lastrd[2]);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] pool [16];
    logic [15:0] a;
    logic        rd, wr;
    int          r;

    tbl[0]  = '{1'b0, 1'b1, 16'h0005, 16'hBEEF, 1'b0, 16'h0000};
    tbl[1]  = '{1'b1, 1'b0, 16'h0005, 16'h0000, 1'b0, 16'hBEEF};
    tbl[2]  = '{1'b0, 1'b1, 16'h0000, 16'h1234, 1'b0, 16'hBEEF};
    tbl[3]  = '{1'b1, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h1234};
    tbl[4]  = '{1'b1, 1'b0, 16'h0400, 16'h0000, 1'b1, 16'h0000};
    tbl[5]  = '{1'b0, 1'b1, 16'h0002, 16'h1111, 1'b0, 16'h0000};
    tbl[6]  = '{1'b1, 1'b1, 16'h0002, 16'h5555, 1'b1, 16'h0000};
    tbl[7]  = '{1'b1, 1'b0, 16'h0002, 16'h0000, 1'b0, 16'h1111};
    tbl[8]  = '{1'b0, 1'b1, 16'h03FF, 16'hA5A5, 1'b0, 16'h1111};
    tbl[9]  = '{1'b1, 1'b0, 16'h03FF, 16'h0000, 1'b0, 16'hA5A5};
    tbl[10] = '{1'b0, 1'b1, 16'hFFFF, 16'h7777, 1'b1, 16'h0000};
    tbl[11] = '{1'b1, 1'b0, 16'h03FF, 16'h0000, 1'b0, 16'hA5A5};
    tbl[12] = '{1'b0, 1'b1, 16'h0003, 16'h3333, 1'b0, 16'hA5A5};
    tbl[13] = '{1'b1, 1'b0, 16'h0005, 16'h0000, 1'b0, 16'hBEEF};

    Reset = 1'b0; MemRead = 1'b0; MemWrite = 1'b0; Addr = '0; WrData = '0;
    for (int i = 0; i < NDUT; i++) lastrd[i] = 16'h0000;

    // Reset state
    repeat (2) @(negedge CLK);
    for (int i = 0; i < NDUT; i++) begin
      chk($sformatf("reset w%0d ready", WL[i]), {31'b0, rdy[i]}, 0);
      chk($sformatf("reset w%0d err", WL[i]), {31'b0, er[i]}, 0);
      chk($sformatf("reset w%0d busy", WL[i]), {31'b0, bsy[i]}, 0);
      chk($sformatf("reset w%0d rddata", WL[i]), {16'b0, rdd[i]}, 0);
    end
    Reset = 1'b1;

    // Directed vector table
    for (int t = 0; t < 14; t++) begin
      run_txn(tbl[t].rd, tbl[t].wr, tbl[t].a, tbl[t].d, 5, 1'b0);
      model_apply(tbl[t].rd, tbl[t].wr, tbl[t].a, tbl[t].d);
      check_txn($sformatf("vec%0d", t), tbl[t].exp_err,
                tbl[t].exp_rd, tbl[t].exp_rd, tbl[t].exp_rd);
    end

    // Level-held read: exactly one Ready, Busy until the request falls
    model_txn("held_read", 1'b1, 1'b0, 16'h0003, 16'h0000, 10, 1'b0);

    // Reset during wait states of a write
    model_txn("pre7", 1'b0, 1'b1, 16'h0007, 16'h0777, 5, 1'b0);
    @(negedge CLK);
    MemWrite = 1'b1; Addr = 16'h0007; WrData = 16'hAAAA;
    @(negedge CLK);
    @(negedge CLK);
    chk("rst_mid pre w1 busy", {31'b0, bsy[1]}, 1);
    chk("rst_mid pre w3 busy", {31'b0, bsy[2]}, 1);
    Reset = 1'b0;
    #1;
    for (int i = 0; i < NDUT; i++) begin
      chk($sformatf("rst_mid w%0d ready", WL[i]), {31'b0, rdy[i]}, 0);
      chk($sformatf("rst_mid w%0d err", WL[i]), {31'b0, er[i]}, 0);
      chk($sformatf("rst_mid w%0d busy", WL[i]), {31'b0, bsy[i]}, 0);
      chk($sformatf("rst_mid w%0d rddata", WL[i]), {16'b0, rdd[i]}, 0);
      lastrd[i] = 16'h0000;
    end
    // WAIT=0 reached its access edge before reset; the others did not.
    mem_m[0][7] = 16'hAAAA;
    @(negedge CLK);
    MemWrite = 1'b0;
    Reset    = 1'b1;
    model_txn("rst_mid read7", 1'b1, 1'b0, 16'h0007, 16'h0000, 5, 1'b0);

    // Addr/WrData changed while waiting: original values must be used
    model_txn("pre9", 1'b0, 1'b1, 16'h0009, 16'h0909, 5, 1'b0);
    model_txn("pre10", 1'b0, 1'b1, 16'h000A, 16'h1010, 5, 1'b0);
    model_txn("latch_wr", 1'b0, 1'b1, 16'h0009, 16'h9999, 5, 1'b1);
    model_txn("latch_rd9", 1'b1, 1'b0, 16'h0009, 16'h0000, 5, 1'b0);
    model_txn("latch_rd10", 1'b1, 1'b0, 16'h000A, 16'h0000, 5, 1'b0);

    // Randomized traffic against the model
    for (int i = 0; i < 16; i++) begin
      pool[i] = 16'($urandom_range(0, 1023));
      model_txn($sformatf("rpre%0d", i), 1'b0, 1'b1, pool[i], 16'($urandom), 5, 1'b0);
    end
    for (int n = 0; n < 40; n++) begin
      r  = $urandom_range(0, 9);
      a  = pool[$urandom_range(0, 15)];
      rd = $urandom_range(0, 1) == 1;
      wr = !rd;
      if (r == 0) begin
        rd = 1'b1; wr = 1'b1;
      end else if (r == 1) begin
        a = a | (16'($urandom_range(1, 63)) << 10);
      end
      model_txn($sformatf("rand%0d", n), rd, wr, a, 16'($urandom),
                $urandom_range(5, 8), 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
